// File: rtl/grey_decade_counter_pkg.sv
// Shared constants and Johnson (decade Gray) code helpers for the decade counter.
package grey_pkg;
    localparam int DIG_W = 5;
    typedef logic [DIG_W-1:0] dig_t;

    localparam dig_t JOHN_ZERO = 5'b00000;
    localparam dig_t JOHN_NINE = 5'b10000;

    typedef enum logic [1:0] {RB_RAW, RB_BCD, RB_STAT} rb_kind_e;

    function automatic dig_t johnson_up(input dig_t q);
        return {q[3:0], ~q[4]};
    endfunction

    function automatic dig_t johnson_down(input dig_t q);
        return {~q[0], q[4:1]};
    endfunction

    function automatic logic johnson_valid(input dig_t q);
        case (q)
            5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
            5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] johnson_to_bcd(input dig_t q);
        case (q)
            5'b00000: return 4'd0;
            5'b00001: return 4'd1;
            5'b00011: return 4'd2;
            5'b00111: return 4'd3;
            5'b01111: return 4'd4;
            5'b11111: return 4'd5;
            5'b11110: return 4'd6;
            5'b11100: return 4'd7;
            5'b11000: return 4'd8;
            5'b10000: return 4'd9;
            default:  return 4'hF;
        endcase
    endfunction
endpackage

// File: rtl/grey_decade_counter_if.sv
// Control, load and readback bundle between the decade counter and its host.
interface grey_decade_counter_if #(
    parameter int N_DIG = 12,
    parameter int SEL_W = 8
);
    import grey_pkg::*;

    logic                          i_en;
    logic                          i_up;
    logic                          i_load;
    logic [N_DIG-1:0][DIG_W-1:0]   init;
    logic [SEL_W-1:0]              i_sel;
    logic [N_DIG-1:0][DIG_W-1:0]   o_dig;
    logic                          o_carry;
    logic                          o_err;
    logic [7:0]                    o_cnt;

    modport master (
        output i_en, i_up, i_load, init, i_sel,
        input  o_dig, o_carry, o_err, o_cnt
    );

    modport slave (
        input  i_en, i_up, i_load, init, i_sel,
        output o_dig, o_carry, o_err, o_cnt
    );
endinterface

// File: rtl/grey_decade_counter_digit.sv
// One Johnson-coded decade digit: load, step up/down, and repair of invalid codes.
module grey_digit
    import grey_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic up,
    input  logic load,
    input  dig_t ld_val,
    output dig_t q,
    output logic is_term,
    output logic bad
);
    dig_t base;

    // An invalid code behaves as zero: it repairs to 00000 and counts from there.
    assign bad     = !johnson_valid(q);
    assign base    = bad ? JOHN_ZERO : q;
    assign is_term = up ? (base == JOHN_NINE) : (base == JOHN_ZERO);

    always_ff @(posedge clk) begin
        if (rst)
            q <= JOHN_ZERO;
        else if (load)
            q <= ld_val;
        else if (step)
            q <= up ? johnson_up(base) : johnson_down(base);
        else
            q <= base;
    end
endmodule

// File: rtl/grey_decade_counter.sv
// N-digit Johnson decade counter with ripple-free carry chain, sticky error and readback mux.
module grey_decade_counter
    import grey_pkg::*;
#(
    parameter int N_DIG = 12,
    parameter int SEL_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    grey_decade_counter_if.slave  bus
);
    logic [N_DIG-1:0][DIG_W-1:0] dig_q;
    logic [N_DIG-1:0]            term;
    logic [N_DIG-1:0]            bad;
    logic [N_DIG:0]              chain;
    logic                        carry_q, err_q;
    logic [7:0]                  cnt_q, cnt_next;
    logic                        init_bad;
    logic [31:0]                 sel32;
    dig_t                        rb_raw, rb_bcd;
    rb_kind_e                    rb_kind;

    // All digits see the same edge; the chain only decides who steps.
    assign chain[0] = bus.i_en;

    for (genvar k = 0; k < N_DIG; k++) begin : g_dig
        assign chain[k+1] = chain[k] & term[k];

        grey_digit u_dig (
            .clk     (i_clk),
            .rst     (i_rst),
            .step    (chain[k]),
            .up      (bus.i_up),
            .load    (bus.i_load),
            .ld_val  (bus.init[k]),
            .q       (dig_q[k]),
            .is_term (term[k]),
            .bad     (bad[k])
        );
    end

    assign sel32 = 32'(bus.i_sel);

    always_comb begin
        init_bad = 1'b0;
        rb_raw   = JOHN_ZERO;
        rb_bcd   = JOHN_ZERO;
        for (int k = 0; k < N_DIG; k++) begin
            init_bad = init_bad | !johnson_valid(bus.init[k]);
            if (sel32 == 32'(k))         rb_raw = dig_q[k];
            if (sel32 == 32'(k + N_DIG)) rb_bcd = dig_q[k];
        end

        if (sel32 < 32'(N_DIG))
            rb_kind = RB_RAW;
        else if (sel32 < 32'(2 * N_DIG))
            rb_kind = RB_BCD;
        else
            rb_kind = RB_STAT;

        case (rb_kind)
            RB_RAW:  cnt_next = {3'b000, rb_raw};
            RB_BCD:  cnt_next = {4'b0000, johnson_to_bcd(rb_bcd)};
            default: cnt_next = {err_q, carry_q, bus.i_up, bus.i_en, 4'b0000};
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            carry_q <= !bus.i_load & chain[N_DIG];
            err_q   <= bus.i_load ? init_bad : (err_q | (|bad));
            cnt_q   <= cnt_next;
        end
    end

    assign bus.o_dig   = dig_q;
    assign bus.o_carry = carry_q;
    assign bus.o_err   = err_q;
    assign bus.o_cnt   = cnt_q;
endmodule

// File: tb/tb_grey_decade_counter.sv
// Directed scoreboard bench for grey_decade_counter (12 digits, 8-bit select).
module tb_grey_decade_counter;
    logic i_clk = 1'b0;
    logic i_rst;

    grey_decade_counter_if #(.N_DIG(12), .SEL_W(8)) bus ();

    grey_decade_counter #(.N_DIG(12), .SEL_W(8)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          cyc;
        int          kind;   // 0 dig, 1 carry, 2 err, 3 cnt
        logic [63:0] val;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic push(input int kind, input logic [63:0] v, input string nm);
        exp_t e;
        e.cyc = cyc + 1; e.kind = kind; e.val = v; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic exp_dig(input logic [11:0][4:0] v, input string nm);
        push(0, {4'b0000, v}, nm);
    endtask

    task automatic exp_st(input logic c, input logic e, input string nm);
        push(1, 64'(c), {nm, "_carry"});
        push(2, 64'(e), {nm, "_err"});
    endtask

    task automatic exp_cnt(input logic [7:0] v, input string nm);
        push(3, 64'(v), nm);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: compares every expectation due for the edge just taken.
    exp_t        me;
    logic [63:0] mact;
    always @(negedge i_clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            me = sbq.pop_front();
            case (me.kind)
                0:       mact = {4'b0000, bus.o_dig};
                1:       mact = 64'(bus.o_carry);
                2:       mact = 64'(bus.o_err);
                default: mact = 64'(bus.o_cnt);
            endcase
            n_chk++;
            if (me.cyc != cyc || mact !== me.val)
                $display("FAIL %s: got %h expected %h (cycle %0d)", me.name, mact, me.val, cyc);
            else
                n_pass++;
        end
    end

    logic [11:0][4:0] v;

    initial begin
        i_rst = 1'b1;
        bus.i_en = 1'b0; bus.i_up = 1'b1; bus.i_load = 1'b0;
        bus.init = '0;   bus.i_sel = 8'd0;

        // reset
        exp_dig('0, "rst_dig"); exp_st(1'b0, 1'b0, "rst"); exp_cnt(8'h00, "rst_cnt");
        tick();

        // 1: 25 up-counts -> 25
        i_rst = 1'b0; bus.i_en = 1'b1; bus.i_up = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i == 24) begin
                v = '0; v[0] = 5'b11111; v[1] = 5'b00011;
                exp_dig(v, "t1_count25"); exp_st(1'b0, 1'b0, "t1");
            end
            tick();
        end

        // 2: all-9 wraps to all-0 with a one-cycle carry
        bus.i_en = 1'b0; bus.i_load = 1'b1; v = {12{5'b10000}}; bus.init = v;
        exp_dig(v, "t2_load9"); exp_st(1'b0, 1'b0, "t2_load");
        tick();
        bus.i_load = 1'b0; bus.i_en = 1'b1;
        exp_dig('0, "t2_wrap"); exp_st(1'b1, 1'b0, "t2_wrap");
        tick();
        bus.i_en = 1'b0; bus.i_sel = 8'd24;
        exp_dig('0, "t2_hold"); exp_st(1'b0, 1'b0, "t2_after"); exp_cnt(8'h60, "t2_stat");
        tick();

        // 3: 10 counts down to 9, then 8
        bus.i_sel = 8'd0; v = '0; v[1] = 5'b00001; bus.init = v; bus.i_load = 1'b1;
        exp_dig(v, "t3_load10");
        tick();
        bus.i_load = 1'b0; bus.i_en = 1'b1; bus.i_up = 1'b0;
        v = '0; v[0] = 5'b10000;
        exp_dig(v, "t3_down9"); exp_st(1'b0, 1'b0, "t3_down");
        tick();
        v[0] = 5'b11000;
        exp_dig(v, "t3_down8");
        tick();

        // 4: invalid digit repair and sticky error
        bus.i_en = 1'b0; v = '0; v[0] = 5'b01010; bus.init = v; bus.i_load = 1'b1;
        exp_dig(v, "t4_load_bad"); exp_st(1'b0, 1'b1, "t4_load");
        tick();
        bus.i_load = 1'b0; bus.i_en = 1'b1; bus.i_up = 1'b1;
        v[0] = 5'b00001;
        exp_dig(v, "t4_repair"); exp_st(1'b0, 1'b1, "t4_repair");
        tick();
        v[0] = 5'b00011;
        exp_dig(v, "t4_next"); exp_st(1'b0, 1'b1, "t4_sticky");
        tick();
        bus.i_en = 1'b0; bus.init = '0; bus.i_load = 1'b1;
        exp_dig('0, "t4_valid_load"); exp_st(1'b0, 1'b0, "t4_clear");
        tick();

        // 5: load beats enable; reset beats load
        v = {12{5'b10000}}; bus.init = v;
        exp_dig(v, "t5_load9");
        tick();
        v = '0; v[0] = 5'b00111; bus.init = v; bus.i_en = 1'b1; bus.i_up = 1'b1;
        exp_dig(v, "t5_load_en"); exp_st(1'b0, 1'b0, "t5_load_en");
        tick();
        i_rst = 1'b1; bus.init = {12{5'b10000}};
        exp_dig('0, "t5_rst_load"); exp_st(1'b0, 1'b0, "t5_rst"); exp_cnt(8'h00, "t5_rst_cnt");
        tick();
        i_rst = 1'b0; bus.i_en = 1'b0;

        // 6: readback mux
        v = '0; v[0] = 5'b11100; bus.init = v; bus.i_sel = 8'd0;
        exp_dig(v, "t6_load7");
        tick();
        bus.i_load = 1'b0;
        exp_cnt(8'h1C, "t6_raw0");
        tick();
        bus.i_sel = 8'd12;
        exp_cnt(8'h07, "t6_bcd0");
        tick();
        bus.i_sel = 8'd24; bus.i_en = 1'b1; bus.i_up = 1'b1;
        exp_cnt(8'h30, "t6_stat");
        tick();
        bus.i_en = 1'b0; bus.i_sel = 8'd13;
        exp_cnt(8'h00, "t6_bcd1");
        tick();
        v = '0; v[0] = 5'b01010; bus.init = v; bus.i_load = 1'b1;
        exp_st(1'b0, 1'b1, "t6_bad_load");
        tick();
        bus.i_load = 1'b0; bus.i_sel = 8'd12;
        exp_cnt(8'h0F, "t6_bcd_bad");
        tick();
        bus.i_sel = 8'd24; bus.i_up = 1'b0;
        exp_cnt(8'h80, "t6_stat_err");
        tick();
        bus.i_sel = 8'd200; bus.i_up = 1'b1;
        exp_cnt(8'hA0, "t6_stat_hi");
        tick();

        tick(); tick();
        n_chk++;
        if (sbq.size() != 0)
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
